song_sequencer: RTL and testbench

- Plays one of two fixed songs (Song 0 / Song 1) as a timed sequence of note codes.
- Sits between the MusicBoxStateController / GPIO song buttons and the downstream frequency generator that feeds SPI_OutputControllerDac.
- Timing base is 10 ms ticks of CLK_100hz; one song table entry gives one note code and its duration in ticks.

---
 rtl/music_box_song_pkg.sv | 59 +++++
 rtl/song_sequencer_rom.sv | 19 +
 rtl/song_sequencer.sv | 142 ++++++++++++++
 tb/tb_song_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/music_box_song_pkg.sv
// Shared types, note codes and song contents for the music box sequencer.
// Table entries are 12 bits: [11:8] note code, [7:0] duration in ticks.
package music_box_song_pkg;

    localparam int SONG_AW  = 6;
    localparam int SONG_LEN = 2 ** SONG_AW;

    localparam logic [3:0] REST = 4'd0;
    localparam logic [3:0] END  = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY,
        DONE
    } state_t;

    typedef logic [11:0] entry_t;
    typedef logic [SONG_LEN-1:0][11:0] song_t;

    function automatic logic [3:0] entry_code(input entry_t e);
        return e[11:8];
    endfunction

    function automatic logic [7:0] entry_dur(input entry_t e);
        return e[7:0];
    endfunction

    function automatic entry_t mk_entry(input logic [3:0] c,
                                        input logic [7:0] d);
        return {c, d};
    endfunction

    function automatic song_t build_song0();
        song_t s;
        for (int i = 0; i < SONG_LEN; i++)
            s[i] = mk_entry(END, 8'd0);
        s[0] = mk_entry(4'd3, 8'd4);
        s[1] = mk_entry(REST, 8'd2);
        s[2] = mk_entry(4'd5, 8'd1);
        s[3] = mk_entry(END, 8'd0);
        return s;
    endfunction

    // Song 1 fills the whole address space with no END marker.
    function automatic song_t build_song1();
        song_t s;
        for (int i = 0; i < SONG_LEN; i++)
            s[i] = mk_entry(4'(1 + (i % 14)), 8'd1);
        s[0] = mk_entry(4'd7, 8'd2);
        s[1] = mk_entry(4'd9, 8'd6);
        s[2] = mk_entry(4'd2, 8'd0);
        return s;
    endfunction

    localparam song_t SONG0 = build_song0();
    localparam song_t SONG1 = build_song1();

endpackage

// File: rtl/song_sequencer_rom.sv
// Registered-output song table; the top bit of addr selects the song.
module song_rom
    import music_box_song_pkg::*;
#(
    parameter int ADDR_W = SONG_AW
) (
    input  logic          CLK_100hz,
    input  logic [ADDR_W:0] addr,
    output entry_t        entry
);

    always_ff @(posedge CLK_100hz) begin
        if (addr[ADDR_W])
            entry <= SONG1[addr[ADDR_W-1:0]];
        else
            entry <= SONG0[addr[ADDR_W-1:0]];
    end

endmodule

// File: rtl/song_sequencer.sv
// Steps through a song table in 10 ms ticks, producing note code and gate.
// Outputs are registered from next-state values so they change on the edge.
module song_sequencer
    import music_box_song_pkg::*;
#(
    parameter int GAP_TICKS = 1,
    parameter int ADDR_W    = SONG_AW
) (
    input  logic              CLK_100hz,
    input  logic              systemReset_n,
    input  logic              start_n,
    input  logic              song_sel,
    input  logic              abort,
    output logic [3:0]        note_code,
    output logic              note_gate,
    output logic              playing,
    output logic              song_done,
    output logic [ADDR_W-1:0] note_index
);

    localparam logic [7:0] GAP = 8'(GAP_TICKS);

    state_t            state, state_n;
    logic              song, song_n;
    logic [ADDR_W-1:0] idx_n;
    logic [7:0]        cnt, cnt_n;
    logic [7:0]        dur, dur_n;
    logic [3:0]        code_n;
    logic              gate_n;
    logic              st1, st2, st3;
    logic              ab1, ab2;
    logic              start_edge;
    entry_t            rom_q;
    logic [7:0]        rom_dur;

    always_ff @(posedge CLK_100hz or negedge systemReset_n) begin
        if (!systemReset_n) begin
            st1 <= 1'b1;
            st2 <= 1'b1;
            st3 <= 1'b1;
            ab1 <= 1'b0;
            ab2 <= 1'b0;
        end else begin
            st1 <= start_n;
            st2 <= st1;
            st3 <= st2;
            ab1 <= abort;
            ab2 <= ab1;
        end
    end

    assign start_edge = st3 & ~st2;
    assign rom_dur    = entry_dur(rom_q);

    // Address the next state's entry so data is ready during FETCH.
    song_rom #(.ADDR_W(ADDR_W)) u_rom (
        .CLK_100hz(CLK_100hz),
        .addr     ({song_n, idx_n}),
        .entry    (rom_q)
    );

    always_comb begin
        state_n = state;
        song_n  = song;
        idx_n   = note_index;
        cnt_n   = cnt;
        dur_n   = dur;
        code_n  = note_code;
        unique case (state)
            IDLE: begin
                if (start_edge && !ab2) begin
                    state_n = FETCH;
                    song_n  = song_sel;
                    idx_n   = '0;
                end
            end
            FETCH: begin
                if (entry_code(rom_q) == END) begin
                    state_n = DONE;
                end else begin
                    state_n = PLAY;
                    cnt_n   = (rom_dur == 8'd0) ? 8'd1 : rom_dur;
                    dur_n   = cnt_n;
                    code_n  = entry_code(rom_q);
                end
            end
            PLAY: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd1) begin
                    if (note_index == {ADDR_W{1'b1}}) begin
                        state_n = DONE;
                    end else begin
                        state_n = FETCH;
                        idx_n   = note_index + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                idx_n   = '0;
                cnt_n   = '0;
                dur_n   = '0;
                code_n  = REST;
            end
            default: state_n = IDLE;
        endcase
        if (ab2 && state != IDLE) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
            dur_n   = '0;
            code_n  = REST;
        end
        gate_n = (state_n == PLAY) && (code_n != REST) &&
                 ((dur_n <= GAP) || (cnt_n > GAP));
    end

    always_ff @(posedge CLK_100hz or negedge systemReset_n) begin
        if (!systemReset_n) begin
            state      <= IDLE;
            song       <= 1'b0;
            note_index <= '0;
            cnt        <= '0;
            dur        <= '0;
            note_code  <= REST;
            note_gate  <= 1'b0;
            playing    <= 1'b0;
            song_done  <= 1'b0;
        end else begin
            state      <= state_n;
            song       <= song_n;
            note_index <= idx_n;
            cnt        <= cnt_n;
            dur        <= dur_n;
            note_code  <= code_n;
            note_gate  <= gate_n;
            playing    <= (state_n != IDLE);
            song_done  <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: vector table for Song 0 plus
// hand sequences for song select, restart, reset, exhaustion and abort.
module tb_song_sequencer;

    logic       CLK_100hz = 1'b0;
    logic       systemReset_n = 1'b0;
    logic       start_n = 1'b1;
    logic       song_sel = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] note_code;
    logic       note_gate;
    logic       playing;
    logic       song_done;
    logic [5:0] note_index;

    song_sequencer dut (
        .CLK_100hz    (CLK_100hz),
        .systemReset_n(systemReset_n),
        .start_n      (start_n),
        .song_sel     (song_sel),
        .abort        (abort),
        .note_code    (note_code),
        .note_gate    (note_gate),
        .playing      (playing),
        .song_done    (song_done),
        .note_index   (note_index)
    );

    always #5 CLK_100hz = ~CLK_100hz;

    typedef struct {
        logic        start_n;
        logic [12:0] exp;
    } vec_t;

    vec_t        v[16];
    int          tests = 0;
    int          fails = 0;
    logic [12:0] obs;

    assign obs = {note_code, note_gate, playing, song_done, note_index};

    function automatic logic [12:0] e(input int c, input int g,
                                      input int p, input int d,
                                      input int i);
        return {4'(c), 1'(g), 1'(p), 1'(d), 6'(i)};
    endfunction

    task automatic check(input string name, input logic [12:0] got,
                         input logic [12:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got code=%0d gate=%0d play=%0d done=%0d idx=%0d, want code=%0d gate=%0d play=%0d done=%0d idx=%0d",
                     name, got[12:9], got[8], got[7], got[6], got[5:0],
                     exp[12:9], exp[8], exp[7], exp[6], exp[5:0]);
        end
    endtask

    task automatic check_i(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_100hz);
        #1;
    endtask

    int done_cnt, done_at, done_idx, wrap_seen, prev_idx, play_cnt;

    initial begin
        v[0]  = '{1'b0, e(0, 0, 0, 0, 0)};
        v[1]  = '{1'b0, e(0, 0, 0, 0, 0)};
        v[2]  = '{1'b0, e(0, 0, 1, 0, 0)};
        v[3]  = '{1'b0, e(3, 1, 1, 0, 0)};
        v[4]  = '{1'b0, e(3, 1, 1, 0, 0)};
        v[5]  = '{1'b0, e(3, 1, 1, 0, 0)};
        v[6]  = '{1'b0, e(3, 0, 1, 0, 0)};
        v[7]  = '{1'b0, e(3, 0, 1, 0, 1)};
        v[8]  = '{1'b0, e(0, 0, 1, 0, 1)};
        v[9]  = '{1'b0, e(0, 0, 1, 0, 1)};
        v[10] = '{1'b0, e(0, 0, 1, 0, 2)};
        v[11] = '{1'b0, e(5, 1, 1, 0, 2)};
        v[12] = '{1'b0, e(5, 0, 1, 0, 3)};
        v[13] = '{1'b0, e(5, 0, 1, 1, 3)};
        v[14] = '{1'b1, e(0, 0, 0, 0, 0)};
        v[15] = '{1'b1, e(0, 0, 0, 0, 0)};

        step();
        step();
        check("reset", obs, e(0, 0, 0, 0, 0));
        systemReset_n = 1'b1;
        step();

        // Song 0 played end to end
        song_sel = 1'b0;
        for (int k = 0; k < 16; k++) begin
            start_n = v[k].start_n;
            step();
            check($sformatf("song0_e%0d", k + 1), obs, v[k].exp);
        end
        start_n = 1'b1;
        repeat (3) step();

        // Song 1 select, ignored restart, async reset mid-note
        song_sel = 1'b1;
        start_n  = 1'b0;
        step();
        step();
        step();
        song_sel = 1'b0;
        check("s1_fetch", obs, e(0, 0, 1, 0, 0));
        step();
        check("s1_first", obs, e(7, 1, 1, 0, 0));
        start_n = 1'b1;
        step();
        check("s1_gap", obs, e(7, 0, 1, 0, 0));
        start_n = 1'b0;
        step();
        check("s1_fetch2", obs, e(7, 0, 1, 0, 1));
        step();
        check("s1_note2", obs, e(9, 1, 1, 0, 1));
        step();
        check("restart_ignored", obs, e(9, 1, 1, 0, 1));
        #3;
        systemReset_n = 1'b0;
        #1;
        check("async_reset", obs, e(0, 0, 0, 0, 0));
        start_n = 1'b1;
        step();
        step();
        systemReset_n = 1'b1;
        repeat (4) step();
        check("idle_after_reset", obs, e(0, 0, 0, 0, 0));

        // Song 1 runs to address exhaustion
        done_cnt  = 0;
        done_at   = 0;
        done_idx  = 0;
        wrap_seen = 0;
        prev_idx  = 0;
        song_sel  = 1'b1;
        start_n   = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (c == 3)
                song_sel = 1'b0;
            if (song_done) begin
                done_cnt++;
                done_at  = c;
                done_idx = int'(note_index);
            end
            if (playing && int'(note_index) < prev_idx)
                wrap_seen++;
            prev_idx = playing ? int'(note_index) : 0;
            if (c == 14)
                check("dur0_note", obs, e(2, 1, 1, 0, 2));
            if (c == 137)
                check("exhaust_done", obs, e(8, 0, 1, 1, 63));
            if (c == 138)
                check("exhaust_idle", obs, e(0, 0, 0, 0, 0));
        end
        check_i("done_pulses", done_cnt, 1);
        check_i("done_edge", done_at, 137);
        check_i("done_index", done_idx, 63);
        check_i("no_wrap", wrap_seen, 0);
        start_n = 1'b1;
        repeat (3) step();

        // Abort mid-note
        song_sel = 1'b0;
        start_n  = 1'b0;
        repeat (5) step();
        check("abort_pre", obs, e(3, 1, 1, 0, 0));
        abort = 1'b1;
        step();
        check("abort_sync1", obs, e(3, 1, 1, 0, 0));
        step();
        check("abort_sync2", obs, e(3, 0, 1, 0, 0));
        step();
        check("abort_idle", obs, e(0, 0, 0, 0, 0));
        done_cnt = 0;
        play_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (song_done)
                done_cnt++;
        end
        check_i("abort_no_done", done_cnt, 0);

        // Abort and start edge land in the same cycle
        abort   = 1'b0;
        start_n = 1'b1;
        repeat (4) step();
        abort   = 1'b1;
        start_n = 1'b0;
        repeat (3) step();
        abort = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (playing)
                play_cnt++;
        end
        check_i("abort_blocks_start", play_cnt, 0);
        check("abort_start_idle", obs, e(0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
